// File: rtl/dec_scan_seq_pkg.sv
// Shared definitions for the decoder scan sequencer: FSM state encoding,
// index width and the index step helper.
package dec_scan_seq_pkg;

  localparam int unsigned IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One index step; callers handle the end-of-range wrap before calling.
  function automatic logic [IDX_W-1:0] step_idx(input logic [IDX_W-1:0] cur,
                                                input logic             down);
    return down ? (cur - IDX_W'(1)) : (cur + IDX_W'(1));
  endfunction

endpackage

// File: rtl/dec_scan_seq_prescaler.sv
// Dwell-time prescaler: counts 0..CLK_DIV-1 and flags a tick on the last count.
// clr forces the count to zero; hold freezes it and suppresses the tick.
module dec_scan_prescaler #(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLK_DIV - 1);

  logic [PW-1:0] count_q;
  logic [PW-1:0] count_d;
  logic          at_term;

  assign at_term = (count_q == TERM);
  assign tick    = at_term && !hold;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (!hold) begin
      count_d = at_term ? '0 : (count_q + PW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dec_scan_seq.sv
// Scan sequencer driving a 5-to-32 decoder select index and enable.
// Optional feature: define DEC_SCAN_PAUSE_EN to add the pause input.
module dec_scan_seq
  import dec_scan_seq_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000,
  parameter int unsigned LAST    = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             oneshot,
`ifdef DEC_SCAN_PAUSE_EN
  input  logic             pause,
`endif
  output logic [IDX_W-1:0] idx,
  output logic             en,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             en_q;
  logic             busy_q;
  logic             done_q;
  logic             dir_q;
  logic             oneshot_q;

  logic             tick;
  logic             clr;
  logic             hold;
  logic             at_end;
  logic [IDX_W-1:0] idx_d;

  // Prescaler is held at zero outside RUN, which covers the clear on RUN entry.
  assign clr = (state_q != ST_RUN) || stop;

`ifdef DEC_SCAN_PAUSE_EN
  assign hold = pause && (state_q == ST_RUN);
`else
  assign hold = 1'b0;
`endif

  dec_scan_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .hold  (hold),
    .tick  (tick)
  );

  assign at_end = dir_q ? (idx_q == '0) : (idx_q == LAST_IDX);

  always_comb begin
    idx_d = step_idx(idx_q, dir_q);
    if (at_end) begin
      idx_d = dir_q ? LAST_IDX : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dir_q     <= 1'b0;
      oneshot_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_q   <= ST_RUN;
            en_q      <= 1'b1;
            busy_q    <= 1'b1;
            idx_q     <= dir ? LAST_IDX : '0;
            dir_q     <= dir;
            oneshot_q <= oneshot;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            idx_q   <= '0;
          end else if (tick) begin
            if (at_end && oneshot_q) begin
              state_q <= ST_DONE;
              en_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_d;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign idx  = idx_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_dec_scan_seq.sv
// Directed bench for dec_scan_seq with CLK_DIV=4, LAST=31.
// Pause scenario is exercised only when DEC_SCAN_PAUSE_EN is defined.
module tb_dec_scan_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       dir;
  logic       oneshot;
`ifdef DEC_SCAN_PAUSE_EN
  logic       pause;
`endif
  logic [4:0] idx;
  logic       en;
  logic       busy;
  logic       done;

  int unsigned tests;
  int unsigned fails;

  dec_scan_seq #(
    .CLK_DIV (4),
    .LAST    (31)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .dir     (dir),
    .oneshot (oneshot),
`ifdef DEC_SCAN_PAUSE_EN
    .pause   (pause),
`endif
    .idx     (idx),
    .en      (en),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference 5-to-32 decoder fed by idx/en.
  function automatic logic [31:0] dec32(input logic [4:0] i, input logic e);
    logic [31:0] one;
    one = 32'd1;
    return e ? (one << i) : 32'd0;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_en"},   32'(en),   32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [4:0] e5;
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    dir     = 1'b0;
    oneshot = 1'b0;
`ifdef DEC_SCAN_PAUSE_EN
    pause   = 1'b0;
`endif

    // 1. reset held while inputs toggle
    for (int i = 0; i < 6; i++) begin
      start   = 1'($urandom_range(0, 1));
      stop    = 1'($urandom_range(0, 1));
      dir     = 1'($urandom_range(0, 1));
      oneshot = 1'($urandom_range(0, 1));
      step();
      chk("rst_idx", 32'(idx), 32'd0);
      chk_idle("rst");
      chk("rst_dec", dec32(idx, en), 32'd0);
    end
    start = 1'b0; stop = 1'b0; dir = 1'b0; oneshot = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk_idle("idle0");
    chk("idle0_idx", 32'(idx), 32'd0);

    // 2. one-shot up scan
    dir = 1'b0; oneshot = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 128; k++) begin
      chk("up_idx",  32'(idx),  32'(k / 4));
      chk("up_en",   32'(en),   32'd1);
      chk("up_busy", 32'(busy), 32'd1);
      chk("up_done", 32'(done), 32'd0);
      step();
    end
    chk("os_done",     32'(done), 32'd1);
    chk("os_done_en",  32'(en),   32'd0);
    chk("os_done_bsy", 32'(busy), 32'd0);
    chk("os_done_idx", 32'(idx),  32'd31);
    step();
    chk_idle("after_done");
    step();
    chk_idle("after_done2");

    // 3. continuous down scan with wrap
    dir = 1'b1; oneshot = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 136; k++) begin
      e5 = 5'(31 - k / 4);
      chk("dn_idx",  32'(idx),  32'(e5));
      chk("dn_en",   32'(en),   32'd1);
      chk("dn_busy", 32'(busy), 32'd1);
      chk("dn_done", 32'(done), 32'd0);
      chk("dn_dec",  dec32(idx, en), 32'd1 << e5);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_idle("dn_stop");
    chk("dn_stop_idx", 32'(idx), 32'd0);

    // 4. stop at idx=10 during continuous up scan
    dir = 1'b0; oneshot = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 41; k++) step();
    chk("pre_stop_idx", 32'(idx), 32'd10);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_idx", 32'(idx), 32'd0);
    chk_idle("stop");
    for (int k = 0; k < 8; k++) begin
      step();
      chk_idle("stop_hold");
    end
    start = 1'b1; stop = 1'b1;
    step();
    chk_idle("start_stop");
    step();
    chk_idle("start_stop2");
    start = 1'b0; stop = 1'b0;

    // stop coinciding with the terminal tick of a one-shot pass
    dir = 1'b0; oneshot = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 127; k++) step();
    chk("term_idx", 32'(idx), 32'd31);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_idle("term_stop");
    chk("term_stop_idx", 32'(idx), 32'd0);
    step();
    chk_idle("term_stop2");

    // 5. async reset mid-scan at idx=17
    dir = 1'b0; oneshot = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 69; k++) step();
    chk("pre_rst_idx", 32'(idx), 32'd17);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_idx", 32'(idx), 32'd0);
    chk_idle("arst");
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk_idle("post_rst");
      chk("post_rst_idx", 32'(idx), 32'd0);
    end

`ifdef DEC_SCAN_PAUSE_EN
    // 6. pause at idx=5 for 20 cycles
    dir = 1'b0; oneshot = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 21; k++) step();
    chk("pre_pause_idx", 32'(idx), 32'd5);
    pause = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("pause_idx", 32'(idx), 32'd5);
      chk("pause_en",  32'(en),  32'd1);
    end
    pause = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("resume_idx", 32'(idx), 32'd5);
      step();
    end
    chk("resume_step", 32'(idx), 32'd6);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_idle("pause_stop");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
